if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one request at a time to instruction memory, which has variable latency.
- Presents a fetched {pc, instr} pair to IF/ID and holds it until IF/ID accepts it.
- Handles EX-stage redirects, including discarding a memory response that is already in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven when no valid instruction is held.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; the same signal gates IF/ID.
- redirect  in  1  taken branch/jump resolved in EX.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0 internally.
- imem_req  out  1  request strobe; one cycle per request.
- imem_addr  out  32  word-aligned fetch address; valid only while imem_req=1.
- imem_rvalid  in  1  response valid; arrives 1 or more cycles after imem_req.
- imem_rdata  in  32  instruction word; valid with imem_rvalid.
- pc_out  out  32  PC of the held instruction; feeds IF/ID pc_in.
- instr_out  out  32  held instruction, or NOP_INSTR; feeds IF/ID instr_in.
- instr_valid  out  1  instr_out holds a real fetched instruction.

Behaviour:
- States: FETCH, WAIT, HOLD, DRAIN. Internal pc_reg holds the next fetch address.
- Reset (synchronous, overrides everything):
  - pc_reg=RESET_PC, state=FETCH.
  - pc_out=0, instr_out=NOP_INSTR, instr_valid=0, imem_req=0 in the reset cycle.
- Outstanding requests: at most one at any time.
- FETCH:
  - Drives imem_req=1, imem_addr=pc_reg.
  - Next state WAIT.
  - If redirect=1: the request is still issued but treated as stale; pc_reg<=target; next state DRAIN.
- WAIT:
  - imem_req=0; waits for imem_rvalid.
  - On rvalid with no redirect: instr_out<=imem_rdata, pc_out<=pc_reg, instr_valid<=1; next state HOLD.
  - On redirect without rvalid: pc_reg<=target; next state DRAIN.
  - On redirect with rvalid in the same cycle: response dropped; pc_reg<=target; next state FETCH.
- HOLD:
  - instr_valid=1 and outputs are stable.
  - redirect=1 (priority over stall): instr_valid<=0, instr_out<=NOP_INSTR, pc_reg<=target; next state FETCH.
  - stall=1: hold everything, no request issued.
  - stall=0: IF/ID consumes the instruction this edge.
    - Same cycle: imem_req=1, imem_addr=pc_reg+4.
    - pc_reg<=pc_reg+4, instr_valid<=0, instr_out<=NOP_INSTR; next state WAIT.
- DRAIN:
  - imem_req=0; waits for the stale response.
  - On imem_rvalid: data discarded; next state FETCH.
  - A further redirect updates pc_reg only.
  - Redirect and rvalid in the same cycle: pc_reg<=new target; next state FETCH.
- Bubbles: whenever instr_valid=0, instr_out=NOP_INSTR, so IF/ID latches a bubble.
- Stall with instr_valid=0: stall is ignored, since nothing is held.
- Arithmetic: PC increment is +4 modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
- Protocol violation: imem_rvalid in FETCH or HOLD is ignored, with no state change.
- Throughput: with 1-cycle memory latency and no stalls, one instruction every 2 cycles.

Decomposition:
- Shared riscv_pkg holds:
  - NOP_INSTR constant and RESET_PC default.
  - fetch-state enum (FETCH/WAIT/HOLD/DRAIN), 2 bits.
  - XLEN=32.
- No sub-module. PC register, state register and output holding register are all local to if_fetch_stage.

Test Plan:
- Reset, then 1-cycle memory returning 0x00500093 at 0x0:
  - imem_req at cycle 1, addr 0x0.
  - instr_valid=1, pc_out=0x0, instr_out=0x00500093 at cycle 3.
  - next imem_addr=0x4 in the consuming cycle.
- Instruction held with stall=1 for 3 cycles:
  - pc_out, instr_out and instr_valid unchanged; imem_req stays 0.
  - On release, imem_addr=pc_out+4.
- Redirect to 0x0000_0103 while in WAIT, memory latency 3:
  - stale response dropped; no instr_valid.
  - next imem_addr=0x0000_0100.
  - instr_valid first asserts with pc_out=0x100.
- Redirect and imem_rvalid in the same cycle in WAIT:
  - data never appears on instr_out.
  - FETCH of the target in the next cycle, with no DRAIN cycle.
- pc_reg=0xFFFF_FFFC, consume instruction:
  - next imem_addr=0x0000_0000.
- Reset asserted in WAIT while a response is pending, then a late imem_rvalid during the reset cycle:
  - outputs return to reset values.
  - first post-reset imem_addr=RESET_PC.
  - late response data does not appear on instr_out.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: data width, bubble encoding, reset PC
// and the instruction-fetch state encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps at most one imem request
// outstanding, holds {pc, instr} for IF/ID and flushes on EX redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);
  import riscv_pkg::*;

  fetch_state_t state, state_next;

  logic [31:0] pc_reg;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        consume;

  assign pc_inc  = pc_reg + 32'd4;
  assign target  = redirect_pc & ~32'd3;
  assign consume = (state == HOLD) && !redirect && !stall;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: state_next = redirect ? DRAIN : WAIT;
      WAIT: begin
        // A redirect coinciding with the response retires the stale request at once.
        if (redirect)         state_next = imem_rvalid ? FETCH : DRAIN;
        else if (imem_rvalid) state_next = HOLD;
      end
      HOLD: begin
        if (redirect)    state_next = FETCH;
        else if (!stall) state_next = WAIT;
      end
      DRAIN: if (imem_rvalid) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // The consuming HOLD cycle issues the next sequential fetch directly.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_reg;
    if (!reset) begin
      if (state == FETCH) begin
        imem_req = 1'b1;
      end else if (consume) begin
        imem_req  = 1'b1;
        imem_addr = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      pc_out      <= '0;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: if (redirect) pc_reg <= target;
        WAIT: begin
          if (redirect) begin
            pc_reg <= target;
          end else if (imem_rvalid) begin
            instr_out   <= imem_rdata;
            pc_out      <= pc_reg;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_reg      <= target;
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
          end else if (!stall) begin
            pc_reg      <= pc_inc;
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
          end
        end
        DRAIN: if (redirect) pc_reg <= target;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: random stalls, redirects and memory
// latency checked against a sequential instruction-stream model.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;

  if_fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Expected next instruction handed to IF/ID.
  ent_t q[$];
  ent_t e;

  int          checks = 0;
  int          errors = 0;
  int          timeouts = 0;
  int          timeouts_seen = 0;
  int unsigned lat_max = 1;
  logic        a_mode = 1'b1;

  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          rst_seen = 0;
  int          post_cyc = 0;
  int          idle = 0;
  logic        first_req = 1'b0;
  logic        first_valid = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory responder, scoreboard and protocol monitor.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(mem_addr);
        mem_pend    = 1'b0;
      end
    end
    if (timeouts != timeouts_seen) begin
      chk("stim_wait_bound", 32'd1, 32'd0);
      timeouts_seen = timeouts;
    end
    if (reset) begin
      rst_seen++;
      chk("req_in_reset", {31'd0, imem_req}, 32'd0);
      if (rst_seen >= 2) begin
        chk("reset_pc_out", pc_out, 32'd0);
        chk("reset_instr_out", instr_out, NOP);
        chk("reset_valid", {31'd0, instr_valid}, 32'd0);
      end
      q.delete();
      q.push_back('{RST_PC, word_at(RST_PC)});
      mem_pend    = 1'b0;
      post_cyc    = 0;
      idle        = 0;
      first_req   = 1'b1;
      first_valid = 1'b1;
    end else begin
      rst_seen = 0;
      post_cyc++;
      if (instr_valid) begin
        chk("pc_out", pc_out, q[0].pc);
        chk("instr_out", instr_out, q[0].instr);
        idle = 0;
        if (first_valid) begin
          if (a_mode) chk("first_valid_cycle", post_cyc, 3);
          first_valid = 1'b0;
        end
      end else begin
        chk("bubble", instr_out, NOP);
        idle++;
        if (idle == 200) chk("liveness", 32'd0, 32'd1);
      end
      if (instr_valid && stall && !redirect) chk("req_in_stall", {31'd0, imem_req}, 32'd0);
      if (redirect) begin
        q.delete();
        q.push_back('{redirect_pc & ~32'd3, word_at(redirect_pc & ~32'd3)});
      end else if (instr_valid && !stall) begin
        e = q.pop_front();
        q.push_back('{e.pc + 32'd4, word_at(e.pc + 32'd4)});
      end
      if (imem_req) begin
        chk("one_outstanding", {31'd0, mem_pend}, 32'd0);
        if (!redirect) chk("req_addr", imem_addr, q[0].pc);
        if (first_req) begin
          chk("first_req_cycle", post_cyc, 1);
          chk("first_req_addr", imem_addr, RST_PC);
          first_req = 1'b0;
        end
        mem_pend = 1'b1;
        mem_cnt  = int'($urandom_range(1, lat_max));
        mem_addr = imem_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_target(output logic [31:0] t);
    case ($urandom_range(0, 3))
      0: t = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      1: t = 32'h0000_0103;
      2: t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: t = $urandom;
    endcase
  endtask

  initial begin
    logic [31:0] t;
    logic        hit;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    reset = 1'b0;

    // Single-cycle memory, free-running.
    repeat (20) step();

    // Hold a valid instruction with stall for three cycles.
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (instr_valid) hit = 1'b1;
      else step();
    end
    if (!hit) timeouts++;
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (6) step();
    a_mode = 1'b0;

    // Redirect to 0x103 while a slow request is pending.
    lat_max = 3;
    repeat (8) step();
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (mem_pend && !instr_valid) hit = 1'b1;
      else step();
    end
    if (!hit) timeouts++;
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    repeat (15) step();

    // Wrap-around fetch from the top of the address space.
    lat_max = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    repeat (12) step();

    // Randomised stalls, redirects and latencies.
    lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      stall    = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 6);
      rand_target(t);
      redirect_pc = t;
      step();
    end
    stall = 1'b0; redirect = 1'b0;

    // Reset landing on the cycle a late response arrives.
    lat_max = 3;
    repeat (10) step();
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (mem_pend && mem_cnt == 1) hit = 1'b1;
      else step();
    end
    if (!hit) timeouts++;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (20) step();

    lat_max = 2;
    for (int i = 0; i < 300; i++) begin
      stall    = ($urandom_range(0, 99) < 20);
      redirect = ($urandom_range(0, 99) < 4);
      rand_target(t);
      redirect_pc = t;
      step();
    end
    stall = 1'b0; redirect = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
